runahead_spec_queue: RTL and testbench

Parametrised runahead instruction FIFO with speculation tracking, sitting between fetch/dependency check and issue in the memory/runahead path. Instructions blocked on dirty or to-be-written operands are pushed with forwarding hints and a stack tag. They are later popped in order when issue accepts them. Entries pushed during branch speculation are tagged, counted, and discarded in one cycle on a mispredict by rolling back the write pointer. A new speculation window cannot open until the previous window's entries have drained.

---
 rtl/runahead_spec_queue_if.sv | 46 ++++
 rtl/runahead_spec_queue.sv | 120 ++++++++++++
 tb/tb_runahead_spec_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/runahead_spec_queue_if.sv
// Handshake/status bundle between fetch/dependency check, the runahead queue and issue.
interface runahead_spec_queue_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int CNT_W       = 6
);
    // push side
    logic                   push_valid;
    logic                   push_ready;
    logic [INSTR_WIDTH-1:0] push_instr;
    logic                   push_a_fwd;
    logic                   push_b_fwd;
    logic [TAG_WIDTH-1:0]   push_tag;
    // speculation control
    logic                   spec_begin;
    logic                   spec_resolve;
    logic                   spec_mispredict;
    // issue side
    logic                   issue_valid;
    logic                   issue_ready;
    logic [INSTR_WIDTH-1:0] issue_instr;
    logic                   issue_a_fwd;
    logic                   issue_b_fwd;
    logic [TAG_WIDTH-1:0]   issue_tag;
    logic                   issue_spec;
    // status
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       spec_count;
    logic [1:0]             spec_state;

    modport master (
        output push_valid, push_instr, push_a_fwd, push_b_fwd, push_tag,
               spec_begin, spec_resolve, spec_mispredict, issue_ready,
        input  push_ready, issue_valid, issue_instr, issue_a_fwd, issue_b_fwd,
               issue_tag, issue_spec, full, empty, count, spec_count, spec_state
    );

    modport slave (
        input  push_valid, push_instr, push_a_fwd, push_b_fwd, push_tag,
               spec_begin, spec_resolve, spec_mispredict, issue_ready,
        output push_ready, issue_valid, issue_instr, issue_a_fwd, issue_b_fwd,
               issue_tag, issue_spec, full, empty, count, spec_count, spec_state
    );
endinterface

// File: rtl/runahead_spec_queue.sv
// Runahead instruction FIFO with speculation tagging and one-cycle mispredict rollback.
// Speculative entries are always the youngest run while a window is open, so a
// mispredict simply pulls the write pointer back over them.
module runahead_spec_queue #(
    parameter int DEPTH       = 32,
    parameter int INSTR_WIDTH = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic                 clk_en,
    runahead_spec_queue_if.slave bus
);
    localparam int AW = CNT_W - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SPEC = 2'd1, DRAIN = 2'd2} state_t;

    typedef struct packed {
        logic                   spec;
        logic [TAG_WIDTH-1:0]   tag;
        logic                   a_fwd;
        logic                   b_fwd;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [CNT_W-1:0] r_wp, r_rp, r_spec_cnt;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic             w_full, w_empty, w_push, w_pop, w_pop_spec;
    logic             w_resolve, w_mispredict, w_correct, w_spec_tag;
    logic [CNT_W-1:0] w_rollback, w_spec_cnt_nxt, w_wp_nxt;
    entry_t           w_head, w_new;

    // Reset asserts asynchronously and releases synchronously to clk.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) r_rst_sync <= 2'b00;
        else              r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_empty = (r_wp == r_rp);
    assign w_head  = r_mem[r_rp[AW-1:0]];

    // Resolve only means something while a window is open.
    assign w_resolve    = clk_en && (r_state == SPEC) && bus.spec_resolve;
    assign w_mispredict = w_resolve && bus.spec_mispredict;
    assign w_correct    = w_resolve && !bus.spec_mispredict;
    assign w_spec_tag   = ((r_state == SPEC) || ((r_state == IDLE) && bus.spec_begin)) && !w_correct;

    assign w_push     = clk_en && bus.push_valid && !w_full && !w_mispredict;
    assign w_pop      = clk_en && !w_empty && bus.issue_ready;
    assign w_pop_spec = w_pop && w_head.spec;

    // A speculative head popped on the mispredict cycle is consumed, not rolled back.
    assign w_rollback     = r_spec_cnt - CNT_W'(w_pop_spec);
    assign w_spec_cnt_nxt = w_mispredict ? '0
                          : r_spec_cnt + CNT_W'(w_push && w_spec_tag) - CNT_W'(w_pop_spec);
    assign w_wp_nxt       = w_mispredict ? (r_wp - w_rollback) : (r_wp + CNT_W'(w_push));

    assign w_new = '{spec: w_spec_tag, tag: bus.push_tag, a_fwd: bus.push_a_fwd,
                     b_fwd: bus.push_b_fwd, instr: bus.push_instr};

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= w_new;
    end

    // Pointers and speculative count.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_spec_cnt <= '0;
        end else if (clk_en) begin
            r_wp       <= w_wp_nxt;
            r_rp       <= r_rp + CNT_W'(w_pop);
            r_spec_cnt <= w_spec_cnt_nxt;
        end
    end

    // Speculation window state register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Window transitions; a new window waits until the old one has drained.
    always_comb begin
        w_state_nxt = r_state;
        if (clk_en) begin
            case (r_state)
                IDLE:    if (bus.spec_begin) w_state_nxt = SPEC;
                SPEC: begin
                    if (w_mispredict)   w_state_nxt = IDLE;
                    else if (w_correct) w_state_nxt = (w_spec_cnt_nxt != '0) ? DRAIN : IDLE;
                end
                DRAIN:   if (w_spec_cnt_nxt == '0) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.push_ready  = !w_full;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.issue_valid = !w_empty;
    assign bus.issue_instr = w_head.instr;
    assign bus.issue_a_fwd = w_head.a_fwd;
    assign bus.issue_b_fwd = w_head.b_fwd;
    assign bus.issue_tag   = w_head.tag;
    assign bus.issue_spec  = w_head.spec;
    assign bus.count       = r_wp - r_rp;
    assign bus.spec_count  = r_spec_cnt;
    assign bus.spec_state  = r_state;
endmodule

// File: tb/tb_runahead_spec_queue.sv
// Directed bench for runahead_spec_queue against a queue-based behavioural model.
module tb_runahead_spec_queue;
    localparam int DEPTH = 8;
    localparam int IW    = 16;
    localparam int TW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          spec;
        logic [TW-1:0] tag;
        logic          a;
        logic          b;
        logic [IW-1:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    ent_t q[$];
    int   m_state = 0;

    runahead_spec_queue_if #(.INSTR_WIDTH(IW), .TAG_WIDTH(TW), .CNT_W(CW)) bus ();

    runahead_spec_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .async_rst_n (rst_n),
        .clk_en      (clk_en),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        int ns;
        if (chk_en) begin
            ns = 0;
            foreach (q[i]) if (q[i].spec) ns++;
            chk("count",       bus.count,       q.size());
            chk("spec_count",  bus.spec_count,  ns);
            chk("empty",       bus.empty,       q.size() == 0);
            chk("issue_valid", bus.issue_valid, q.size() != 0);
            chk("full",        bus.full,        q.size() == DEPTH);
            chk("push_ready",  bus.push_ready,  q.size() != DEPTH);
            chk("spec_state",  bus.spec_state,  m_state);
            if (q.size() != 0) begin
                chk("issue_instr", bus.issue_instr, q[0].instr);
                chk("issue_tag",   bus.issue_tag,   q[0].tag);
                chk("issue_a_fwd", bus.issue_a_fwd, q[0].a);
                chk("issue_b_fwd", bus.issue_b_fwd, q[0].b);
                chk("issue_spec",  bus.issue_spec,  q[0].spec);
            end
            if (m_state == 2 && ns > 0) chk("drain_head_spec", bus.issue_spec, 1);
        end
    end

    // Advance model and DUT by one clock with the inputs currently applied.
    task automatic cyc();
        ent_t nq[$];
        ent_t t[$];
        ent_t e;
        int   ns, nst;
        bit   pop, mis, cor, tspec, push;
        pop   = clk_en && q.size() > 0 && bus.issue_ready;
        mis   = clk_en && m_state == 1 && bus.spec_resolve && bus.spec_mispredict;
        cor   = clk_en && m_state == 1 && bus.spec_resolve && !bus.spec_mispredict;
        tspec = (m_state == 1 || (m_state == 0 && bus.spec_begin)) && !cor;
        push  = clk_en && bus.push_valid && q.size() < DEPTH && !mis;
        nq = q;
        if (pop) void'(nq.pop_front());
        if (mis) begin
            foreach (nq[i]) if (!nq[i].spec) t.push_back(nq[i]);
            nq = t;
        end
        if (push) begin
            e = '{spec: tspec, tag: bus.push_tag, a: bus.push_a_fwd, b: bus.push_b_fwd, instr: bus.push_instr};
            nq.push_back(e);
        end
        ns = 0;
        foreach (nq[i]) if (nq[i].spec) ns++;
        nst = m_state;
        if (clk_en) begin
            case (m_state)
                0: if (bus.spec_begin) nst = 1;
                1: if (mis) nst = 0; else if (cor) nst = (ns > 0) ? 2 : 0;
                2: if (ns == 0) nst = 0;
                default: nst = 0;
            endcase
        end
        @(posedge clk);
        q = nq;
        m_state = nst;
        #1;
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_instr = '0;
        bus.push_a_fwd = 1'b0;
        bus.push_b_fwd = 1'b0;
        bus.push_tag = '0;
        bus.spec_begin = 1'b0;
        bus.spec_resolve = 1'b0;
        bus.spec_mispredict = 1'b0;
        bus.issue_ready = 1'b0;
    endtask

    task automatic drive(bit en, bit pv, logic [15:0] d, bit sb, bit sr, bit sm, bit ir);
        clk_en = en;
        bus.push_valid = pv;
        bus.push_instr = d;
        bus.push_a_fwd = d[0];
        bus.push_b_fwd = d[1];
        bus.push_tag = d[7:4];
        bus.spec_begin = sb;
        bus.spec_resolve = sr;
        bus.spec_mispredict = sm;
        bus.issue_ready = ir;
        cyc();
        idle_inputs();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_empty"},       bus.empty, 1);
        chk({tag, "_full"},        bus.full, 0);
        chk({tag, "_push_ready"},  bus.push_ready, 1);
        chk({tag, "_issue_valid"}, bus.issue_valid, 0);
        chk({tag, "_count"},       bus.count, 0);
        chk({tag, "_spec_count"},  bus.spec_count, 0);
        chk({tag, "_spec_state"},  bus.spec_state, 0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        #21 rst_n = 1'b1;
        chk_en = 1;
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

        // Fill to DEPTH, then an extra push is dropped.
        for (int k = 1; k <= DEPTH; k++) drive(1, 1, 16'(16'h1111 * k), 0, 0, 0, 0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, DEPTH);
        chk("fill_push_ready", bus.push_ready, 0);
        drive(1, 1, 16'h5A5A, 0, 0, 0, 0);
        chk("overfill_count", bus.count, DEPTH);
        for (int k = 1; k <= DEPTH; k++) begin
            chk("drain_order", bus.issue_instr, 16'h1111 * k);
            drive(1, 0, 0, 0, 0, 0, 1);
        end
        chk("drained_empty", bus.empty, 1);

        // Interleaved push/pop across pointer wraps.
        drive(1, 1, 16'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            chk("wrap_order", bus.issue_instr, i - 1);
            drive(1, 1, 16'(i), 0, 0, 0, 1);
        end
        chk("wrap_count", bus.count, 1);
        drive(1, 0, 0, 0, 0, 0, 1);

        // Mispredict discards the speculative tail and the concurrent push.
        drive(1, 1, 16'hA001, 0, 0, 0, 0);
        drive(1, 1, 16'hA002, 0, 0, 0, 0);
        drive(1, 1, 16'hB001, 1, 0, 0, 0);
        drive(1, 1, 16'hB002, 0, 0, 0, 0);
        drive(1, 1, 16'hB003, 0, 0, 0, 0);
        chk("spec_cnt3", bus.spec_count, 3);
        chk("spec_open", bus.spec_state, 1);
        drive(1, 1, 16'hC001, 0, 1, 1, 0);
        chk("mis_count", bus.count, 2);
        chk("mis_spec_count", bus.spec_count, 0);
        chk("mis_state", bus.spec_state, 0);
        chk("mis_head0", bus.issue_instr, 16'hA001);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("mis_head1", bus.issue_instr, 16'hA002);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("mis_empty", bus.empty, 1);

        // Correct resolve drains, blocks new windows, then reopens.
        drive(1, 1, 16'hD001, 1, 0, 0, 0);
        drive(1, 1, 16'hD002, 0, 0, 0, 0);
        drive(1, 1, 16'hD003, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("resolve_drain", bus.spec_state, 2);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("drain_ignores_begin", bus.spec_state, 2);
        for (int k = 0; k < 3; k++) begin
            chk("drain_spec_head", bus.issue_spec, 1);
            drive(1, 0, 0, 0, 0, 0, 1);
        end
        chk("drain_idle", bus.spec_state, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("reopen", bus.spec_state, 1);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("close_empty_window", bus.spec_state, 0);

        // Mispredict while popping a speculative head.
        drive(1, 1, 16'hE001, 1, 0, 0, 0);
        drive(1, 1, 16'hE002, 0, 0, 0, 0);
        drive(1, 1, 16'hE003, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 1);
        chk("mispop_empty", bus.empty, 1);
        chk("mispop_count", bus.count, 0);
        chk("mispop_spec_count", bus.spec_count, 0);

        // clk_en low freezes everything.
        drive(1, 1, 16'hF001, 1, 0, 0, 0);
        drive(1, 1, 16'hF002, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 16'hF0F3, 1, 1, 0, 1);
        chk("frz_count", bus.count, 2);
        chk("frz_state", bus.spec_state, 1);
        chk("frz_valid", bus.issue_valid, 1);
        chk("frz_head", bus.issue_instr, 16'hF001);

        // Asynchronous reset mid-window.
        #2;
        chk_en = 0;
        rst_n = 1'b0;
        q.delete();
        m_state = 0;
        #1;
        check_reset_outputs("arst");
        #10 rst_n = 1'b1;
        chk_en = 1;
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 16'h7777, 0, 0, 0, 0);
        chk("post_rst_head", bus.issue_instr, 16'h7777);
        drive(1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
